// File: rtl/rmii_tx_pkg.sv
// rmii_tx_pkg: shared types and constants for the RMII transmit frame scheduler.
package rmii_tx_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_SFD, ST_PAY, ST_GAP} state_t;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam int BYTE_CYCLES = 4;
    localparam int CNT_W = 11;
endpackage

// File: rtl/rmii_tx_rr_arb.sv
// rmii_tx_rr_arb: 2-way round-robin arbiter; the channel not served last wins a tie.
module rmii_tx_rr_arb
    import rmii_tx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic last1_q;
    always_comb gnt_o = !en_i ? 2'b00 : &req_i ? (last1_q ? 2'b01 : 2'b10) : req_i;
    // reset as if ch1 was served last so ch0 wins the first tie
    always_ff @(posedge clk_i) begin
        if (rst_i) last1_q <= 1'b1;
        else if (|gnt_o) last1_q <= gnt_o[1];
    end
endmodule

// File: rtl/rmii_tx_sched.sv
// rmii_tx_sched: shares one RMII TX between two byte-stream requesters, adding
// preamble/SFD, pacing payload to the 4-cycle byte slot and enforcing the IFG.
module rmii_tx_sched
    import rmii_tx_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES = 12,
    parameter int MAX_BYTES = 1518
) (
    input  logic       I_clk50m,
    input  logic       I_rst,
    input  logic       I_req0,
    input  logic       I_req1,
    input  logic [7:0] I_data0,
    input  logic [7:0] I_data1,
    input  logic       I_last0,
    input  logic       I_last1,
    output logic       O_grant0,
    output logic       O_grant1,
    output logic       O_rd0,
    output logic       O_rd1,
    output logic       O_ser_txen,
    output logic [7:0] O_ser_data,
    output logic       O_rmii_txen,
    output logic       O_busy,
    output logic       O_err_trunc
);
    // GAP includes the cycle where TX_EN is still high and the arbitration cycle
    localparam int GAP_CYCLES = IFG_BYTES * BYTE_CYCLES + 2;

    state_t           state_q;
    logic [1:0]       ph_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic [1:0]       grant_q;
    logic [1:0]       rd_q;
    logic [7:0]       data_q;
    logic             ser_txen_q;
    logic             rmii_txen_q;
    logic             trunc_q;
    logic [1:0]       win;
    logic             arb_en;
    logic             active;
    logic             sel_last;
    logic             hit_max;
    logic [7:0]       sel_data;
    logic [CNT_W-1:0] cnt_inc;

    assign active = state_q inside {ST_PRE, ST_SFD, ST_PAY};
    assign arb_en = state_q == ST_IDLE || (state_q == ST_GAP && cnt_q == '0);
    assign sel_data = grant_q[1] ? I_data1 : I_data0;
    assign sel_last = grant_q[1] ? I_last1 : I_last0;
    assign cnt_inc = cnt_q + 1'b1;
    assign hit_max = cnt_inc == CNT_W'(MAX_BYTES);

    rmii_tx_rr_arb u_arb (
        .clk_i(I_clk50m),
        .rst_i(I_rst),
        .en_i (arb_en),
        .req_i({I_req1, I_req0}),
        .gnt_o(win)
    );

    always_ff @(posedge I_clk50m) begin
        if (I_rst) begin
            state_q     <= ST_IDLE;
            ph_q        <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            grant_q     <= '0;
            rd_q        <= '0;
            data_q      <= '0;
            ser_txen_q  <= 1'b0;
            rmii_txen_q <= 1'b0;
            trunc_q     <= 1'b0;
        end else begin
            rd_q        <= '0;
            trunc_q     <= 1'b0;
            rmii_txen_q <= active;
            ph_q        <= active ? ph_q + 1'b1 : 2'd0;
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    if (state_q == ST_GAP && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    else if (|win) begin
                        state_q    <= ST_PRE;
                        grant_q    <= win;
                        ser_txen_q <= 1'b1;
                        data_q     <= PREAMBLE_BYTE;
                        cnt_q      <= '0;
                    end else state_q <= ST_IDLE;
                end
                ST_PRE: begin
                    if (ph_q == 2'd3) begin
                        cnt_q <= cnt_inc;
                        if (cnt_q == CNT_W'(PREAMBLE_BYTES - 1)) begin
                            state_q <= ST_SFD;
                            data_q  <= SFD_BYTE;
                            cnt_q   <= '0;
                        end
                    end
                end
                ST_SFD, ST_PAY: begin
                    // TX_EN drops one cycle early so the serializer stops on the slot boundary
                    if (ph_q == 2'd2) begin
                        if (last_q) ser_txen_q <= 1'b0;
                        else rd_q <= grant_q;
                    end
                    if (ph_q == 2'd3) begin
                        if (last_q) begin
                            state_q <= ST_GAP;
                            grant_q <= '0;
                            last_q  <= 1'b0;
                            cnt_q   <= CNT_W'(GAP_CYCLES - 1);
                        end else begin
                            state_q <= ST_PAY;
                            data_q  <= sel_data;
                            cnt_q   <= cnt_inc;
                            last_q  <= sel_last | hit_max;
                            trunc_q <= hit_max & ~sel_last;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign O_grant0    = grant_q[0];
    assign O_grant1    = grant_q[1];
    assign O_rd0       = rd_q[0];
    assign O_rd1       = rd_q[1];
    assign O_ser_txen  = ser_txen_q;
    assign O_ser_data  = data_q;
    assign O_rmii_txen = rmii_txen_q;
    assign O_busy      = state_q != ST_IDLE;
    assign O_err_trunc = trunc_q;
endmodule

// File: tb/tb_rmii_tx_sched.sv
// tb_rmii_tx_sched: directed frames on both channels with hand-computed expectations.
module tb_rmii_tx_sched;
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst, req0, req1, last0, last1;
    logic [7:0] d0, d1;
    logic g0, g1, rd0, rd1, ser_txen, rmii_txen, busy, trunc;
    logic [7:0] ser_data;

    rmii_tx_sched dut (
        .I_clk50m(clk), .I_rst(rst),
        .I_req0(req0), .I_req1(req1),
        .I_data0(d0), .I_data1(d1),
        .I_last0(last0), .I_last1(last1),
        .O_grant0(g0), .O_grant1(g1),
        .O_rd0(rd0), .O_rd1(rd1),
        .O_ser_txen(ser_txen), .O_ser_data(ser_data),
        .O_rmii_txen(rmii_txen), .O_busy(busy), .O_err_trunc(trunc)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // requester model: nf frames of len bytes (len 0 = never last), byte = base + idx
    int nf[2], len[2], idx[2];
    logic [7:0] base[2];
    logic mask[2];
    logic p_rd[2];

    // monitor log
    int rises[$], falls[$], hi_lens[$], gq[$];
    logic [7:0] bytes[$];
    logic [1:0] g_end[$];
    int rdc[2];
    int first_rd0, trunc_cnt, bad_rd, sc;
    logic p_rmii, p_ser, p_rd0m, p_rd1m;

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [7:0] bat(input int i);
        return (i < bytes.size()) ? bytes[i] : 8'hxx;
    endfunction

    task automatic clr();
        rises.delete(); falls.delete(); hi_lens.delete(); gq.delete();
        bytes.delete(); g_end.delete();
        rdc[0] = 0; rdc[1] = 0;
        first_rd0 = -1; trunc_cnt = 0; bad_rd = 0;
    endtask

    initial begin
        p_rmii = 0; p_ser = 0; p_rd0m = 0; p_rd1m = 0; sc = 0;
        p_rd[0] = 0; p_rd[1] = 0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (p_rd[c] && nf[c] > 0) begin
                    if (len[c] != 0 && idx[c] == len[c] - 1) begin
                        idx[c] = 0;
                        nf[c]--;
                    end else idx[c]++;
                end
            end
            p_rd[0] = rd0;
            p_rd[1] = rd1;
            if (rmii_txen && !p_rmii) rises.push_back(cyc);
            if (!rmii_txen && p_rmii) begin
                falls.push_back(cyc);
                hi_lens.push_back(cyc - qat(rises, rises.size() - 1));
            end
            if (ser_txen && !p_ser) begin
                sc = 0;
                gq.push_back(g1 ? 1 : 0);
            end
            if (ser_txen) begin
                if (sc % 4 == 0) bytes.push_back(ser_data);
                sc++;
            end
            if (!ser_txen && p_ser) g_end.push_back({g1, g0});
            if (rd0) rdc[0]++;
            if (rd1) rdc[1]++;
            if (rd0 && first_rd0 < 0) first_rd0 = cyc;
            if ((rd0 && !g0) || (rd1 && !g1) || (rd0 && p_rd0m) || (rd1 && p_rd1m)) bad_rd++;
            if (trunc) trunc_cnt++;
            p_rmii = rmii_txen; p_ser = ser_txen; p_rd0m = rd0; p_rd1m = rd1;
            req0 = nf[0] > 0 && !mask[0];
            req1 = nf[1] > 0 && !mask[1];
            d0 = 8'(int'(base[0]) + idx[0]);
            d1 = 8'(int'(base[1]) + idx[1]);
            last0 = len[0] != 0 && idx[0] == len[0] - 1;
            last1 = len[1] != 0 && idx[1] == len[1] - 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        for (int c = 0; c < 2; c++) begin
            nf[c] = 0; len[c] = 0; idx[c] = 0; mask[c] = 0; base[c] = 8'h00;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_falls(input int n, input int budget);
        int k = 0;
        while (falls.size() < n && k < budget) begin
            step();
            k++;
        end
        if (falls.size() < n) chk("timeout_fall", falls.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        chk("idle", busy, 0);
    endtask

    int t0;

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; last0 = 0; last1 = 0; d0 = 0; d1 = 0;
        clr();
        do_reset();
        chk("rst_g0", g0, 0);
        chk("rst_g1", g1, 0);
        chk("rst_rd0", rd0, 0);
        chk("rst_rd1", rd1, 0);
        chk("rst_stx", ser_txen, 0);
        chk("rst_sdat", ser_data, 0);
        chk("rst_rtx", rmii_txen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trunc", trunc, 0);

        // single 1-byte frame on ch0
        clr();
        base[0] = 8'hA5; len[0] = 1; nf[0] = 1;
        t0 = cyc;
        wait_falls(1, 200);
        chk("t1_rise_lat", qat(rises, 0) - t0, 2);
        chk("t1_len", qat(hi_lens, 0), 36);
        chk("t1_first_rd", first_rd0 - t0, 32);
        chk("t1_nbytes", bytes.size(), 9);
        for (int i = 0; i < 9; i++)
            chk($sformatf("t1_byte%0d", i), bat(i), i < 7 ? 8'h55 : i == 7 ? 8'hD5 : 8'hA5);
        chk("t1_rd0", rdc[0], 1);
        chk("t1_rd1", rdc[1], 0);
        chk("t1_grant", qat(gq, 0), 0);
        chk("t1_gap_busy", busy, 1);
        wait_idle(100);

        // simultaneous requests after reset: ch0 first, then ch1 after a 50-cycle gap
        do_reset();
        clr();
        base[0] = 8'h10; len[0] = 2; nf[0] = 1;
        base[1] = 8'h20; len[1] = 2; nf[1] = 1;
        wait_falls(2, 400);
        chk("t2_g_first", qat(gq, 0), 0);
        chk("t2_g_second", qat(gq, 1), 1);
        chk("t2_gap", qat(rises, 1) - qat(falls, 0), 50);
        chk("t2_len0", qat(hi_lens, 0), 40);
        chk("t2_len1", qat(hi_lens, 1), 40);
        chk("t2_b8", bat(8), 8'h10);
        chk("t2_b9", bat(9), 8'h11);
        chk("t2_b18", bat(18), 8'h20);
        chk("t2_b19", bat(19), 8'h21);
        wait_idle(100);

        // both channels keep requesting: grants alternate
        do_reset();
        clr();
        base[0] = 8'h30; len[0] = 1; nf[0] = 2;
        base[1] = 8'h40; len[1] = 1; nf[1] = 2;
        wait_falls(4, 800);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_grant%0d", i), qat(gq, i), i % 2);
        chk("t3_gap", qat(rises, 3) - qat(falls, 2), 50);
        chk("t3_bad_rd", bad_rd, 0);
        wait_idle(100);

        // ch1 streams without last: truncated at MAX_BYTES
        do_reset();
        clr();
        len[1] = 0; nf[1] = 1;
        wait_falls(1, 7000);
        nf[1] = 0;
        chk("t4_len", qat(hi_lens, 0), 4 * 1526);
        chk("t4_nbytes", bytes.size(), 1526);
        chk("t4_lastbyte", bat(1525), 8'hED);
        chk("t4_trunc", trunc_cnt, 1);
        chk("t4_rd1", rdc[1], 1518);
        chk("t4_rd0", rdc[0], 0);
        chk("t4_gap_busy", busy, 1);
        chk("t4_grant", qat(gq, 0), 1);
        wait_idle(100);

        // reset in the middle of the payload
        do_reset();
        clr();
        base[0] = 8'h50; len[0] = 20; nf[0] = 1;
        t0 = 0;
        while (rdc[0] < 5 && t0 < 300) begin
            step();
            t0++;
        end
        chk("t5_reached", rdc[0] >= 5, 1);
        rst = 1'b1;
        step();
        chk("t5_g0", g0, 0);
        chk("t5_stx", ser_txen, 0);
        chk("t5_sdat", ser_data, 0);
        chk("t5_rtx", rmii_txen, 0);
        chk("t5_busy", busy, 0);
        chk("t5_rd0", rd0, 0);
        rst = 1'b0;
        nf[0] = 0; idx[0] = 0;
        step();
        step();
        clr();
        base[0] = 8'h77; len[0] = 1; idx[0] = 0; nf[0] = 1;
        wait_falls(1, 200);
        chk("t5_new_len", qat(hi_lens, 0), 36);
        chk("t5_new_byte", bat(8), 8'h77);
        chk("t5_new_grant", qat(gq, 0), 0);
        wait_idle(100);

        // request dropped during preamble: frame still completes
        clr();
        base[0] = 8'h60; len[0] = 3; nf[0] = 1;
        t0 = 0;
        while (rises.size() == 0 && t0 < 50) begin
            step();
            t0++;
        end
        mask[0] = 1;
        wait_falls(1, 200);
        chk("t6_len", qat(hi_lens, 0), 44);
        chk("t6_nbytes", bytes.size(), 11);
        chk("t6_lastbyte", bat(10), 8'h62);
        chk("t6_grant_end", g_end.size() > 0 ? g_end[0] : 2'bxx, 2'b01);
        chk("t6_rd0", rdc[0], 3);
        mask[0] = 0;
        wait_idle(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
